// File: rtl/zbt_sram_ctrl_if.sv
// rtl/zbt_sram_ctrl_if.sv - host request/response bus for zbt_sram_ctrl
interface zbt_sram_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [18:0] req_addr;
    logic [35:0] req_wdata;
    logic [3:0]  req_be;
    logic        req_burst;
    logic        rsp_valid;
    logic [35:0] rsp_rdata;
    logic        rsp_last;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_be, req_burst,
        input  req_ready, rsp_valid, rsp_rdata, rsp_last
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_be, req_burst,
        output req_ready, rsp_valid, rsp_rdata, rsp_last
    );
endinterface

// File: rtl/zbt_sram_ctrl.sv
// rtl/zbt_sram_ctrl.sv - pipelined NBT SRAM controller, fixed read latency 3; read bursts with `define ZBT_BURST_EN
module zbt_sram_ctrl (
    input  logic           CK,
    input  logic           RST,
    zbt_sram_ctrl_if.slave bus,
    output logic [18:0]    A,
    output logic           nE1,
    output logic           E2,
    output logic           nE3,
    output logic           nW,
    output logic           nBa,
    output logic           nBb,
    output logic           nBc,
    output logic           nBd,
    output logic           pADV,
    output logic           nCKE,
    output logic           nG,
    output logic           ZZ,
    output logic           nFT,
    output logic           nLBO,
    output logic [35:0]    dq_out,
    output logic           dq_oe,
    input  logic [35:0]    dq_in
);
    typedef struct packed {
        logic        valid;
        logic        write;
        logic [35:0] data;
        logic        last;
    } stage_t;

    // r_s0: cycle after issue, r_s1: SRAM has the address, r_s2: data cycle on the bus
    stage_t      r_s0, r_s1, r_s2;
    logic [1:0]  r_burst_cnt;
    logic [18:0] r_a;
    logic        r_ne1, r_e2, r_ne3, r_nw, r_padv, r_ncke, r_ng, r_dq_oe;
    logic [3:0]  r_nb;
    logic [35:0] r_dq_out, r_rsp_rdata;
    logic        r_rsp_valid, r_rsp_last;
    logic        w_accept, w_burst_start, w_s1_wr, w_s1_rd, w_s2_rd;
    logic        w_unused_s2;

    assign bus.req_ready = ~RST & (r_burst_cnt == 2'd0);
    assign w_accept      = bus.req_valid & bus.req_ready;
`ifdef ZBT_BURST_EN
    assign w_burst_start = w_accept & bus.req_burst & ~bus.req_write;
`else
    logic w_unused_burst;
    assign w_unused_burst = bus.req_burst;
    assign w_burst_start  = 1'b0;
`endif

    assign w_s1_wr     = r_s1.valid & r_s1.write;
    assign w_s1_rd     = r_s1.valid & ~r_s1.write;
    assign w_s2_rd     = r_s2.valid & ~r_s2.write;
    assign w_unused_s2 = ^r_s2.data;

    // Command issue: register address/control pins and push the operation into stage 0
    always_ff @(posedge CK) begin
        if (RST) begin
            r_a         <= '0;
            r_ne1       <= 1'b1;
            r_e2        <= 1'b0;
            r_ne3       <= 1'b1;
            r_nw        <= 1'b1;
            r_nb        <= 4'hF;
            r_padv      <= 1'b0;
            r_ncke      <= 1'b1;
            r_s0        <= '0;
            r_burst_cnt <= 2'd0;
        end else begin
            r_ncke <= 1'b0;
            r_e2   <= 1'b1;
            r_ne3  <= 1'b0;
            if (w_accept) begin
                r_a         <= bus.req_addr;
                r_ne1       <= 1'b0;
                r_nw        <= ~bus.req_write;
                r_nb        <= bus.req_write ? ~bus.req_be : 4'hF;
                r_padv      <= 1'b0;
                r_s0        <= '{valid: 1'b1, write: bus.req_write,
                                 data: bus.req_write ? bus.req_wdata : 36'd0,
                                 last: ~w_burst_start};
                r_burst_cnt <= w_burst_start ? 2'd3 : 2'd0;
`ifdef ZBT_BURST_EN
            end else if (r_burst_cnt != 2'd0) begin
                // burst continuation: SRAM advances its own linear address counter
                r_ne1       <= 1'b0;
                r_nw        <= 1'b1;
                r_nb        <= 4'hF;
                r_padv      <= 1'b1;
                r_s0        <= '{valid: 1'b1, write: 1'b0, data: 36'd0,
                                 last: (r_burst_cnt == 2'd1)};
                r_burst_cnt <= r_burst_cnt - 2'd1;
`endif
            end else begin
                r_ne1  <= 1'b1;
                r_nw   <= 1'b1;
                r_nb   <= 4'hF;
                r_padv <= 1'b0;
                r_s0   <= '0;
            end
        end
    end

    // Data phase: drive write data / open nG two cycles after issue, capture read data one cycle later
    always_ff @(posedge CK) begin
        if (RST) begin
            r_s1        <= '0;
            r_s2        <= '0;
            r_dq_oe     <= 1'b0;
            r_dq_out    <= '0;
            r_ng        <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_last  <= 1'b0;
        end else begin
            r_s1        <= r_s0;
            r_s2        <= r_s1;
            r_dq_oe     <= w_s1_wr;
            r_dq_out    <= w_s1_wr ? r_s1.data : 36'd0;
            r_ng        <= ~w_s1_rd;
            r_rsp_valid <= w_s2_rd;
            r_rsp_rdata <= w_s2_rd ? dq_in : 36'd0;
            r_rsp_last  <= w_s2_rd & r_s2.last;
        end
    end

    assign A                   = r_a;
    assign nE1                 = r_ne1;
    assign E2                  = r_e2;
    assign nE3                 = r_ne3;
    assign nW                  = r_nw;
    assign {nBd, nBc, nBb, nBa} = r_nb;
    assign pADV                = r_padv;
    assign nCKE                = r_ncke;
    assign nG                  = r_ng;
    assign ZZ                  = 1'b0;
    assign nFT                 = 1'b1;
    assign nLBO                = 1'b0;
    assign dq_out              = r_dq_out;
    assign dq_oe               = r_dq_oe;
    assign bus.rsp_valid       = r_rsp_valid;
    assign bus.rsp_rdata       = r_rsp_rdata;
    assign bus.rsp_last        = r_rsp_last;
endmodule
